// File: rtl/rf_pkg.sv
// Shared constants, types and write/pending decoder for the reg_file_sb register bank.
package rf_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 4;
   localparam int unsigned RF_NUM_RD = 2;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;

   function automatic logic [2**RF_ADDR_W-1:0] onehot_dec(input rf_addr_t addr);
      logic [2**RF_ADDR_W-1:0] dec;
      dec       = '0;
      dec[addr] = 1'b1;
      return dec;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array select, write bypass and operand-ready.
// REG_FILE_ZERO_REG_EN suppresses the bypass for address 0 so it always reads zero.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned BYPASS = 1
) (
   input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem,
   input  logic [2**ADDR_W-1:0]             pend,
   input  logic                             wr_en,
   input  logic [ADDR_W-1:0]                wr_addr,
   input  logic [DATA_W-1:0]                wr_data,
   input  logic [ADDR_W-1:0]                rd_addr,
   output logic [DATA_W-1:0]                rd_data,
   output logic                             rd_ready
);

   logic hit;

   always_comb begin
      hit = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
`ifdef REG_FILE_ZERO_REG_EN
      if (rd_addr == '0) hit = 1'b0;
`endif
      rd_data  = hit ? wr_data : mem[rd_addr];
      // a forwarded result makes the operand usable even while still marked pending
      rd_ready = hit || !pend[rd_addr];
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register bank with NUM_RD read ports, optional write bypass and per-register pending bits.
// Define REG_FILE_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_sb
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned NUM_RD = RF_NUM_RD,
   parameter int unsigned BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   input  logic                     pend_set,
   input  logic [ADDR_W-1:0]        pend_addr,
   output logic [2**ADDR_W-1:0]     pend_vec
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] mem_q;
   logic [DEPTH-1:0]             pend_q, pend_d;
   logic [DEPTH-1:0]             wr_dec, pend_dec, wr_sel, pend_sel;

   if (ADDR_W == RF_ADDR_W) begin : g_pkg_dec
      assign wr_dec   = onehot_dec(wr_addr);
      assign pend_dec = onehot_dec(pend_addr);
   end else begin : g_loop_dec
      always_comb begin
         wr_dec   = '0;
         pend_dec = '0;
         for (int i = 0; i < DEPTH; i++) begin
            wr_dec[i]   = (wr_addr == ADDR_W'(i));
            pend_dec[i] = (pend_addr == ADDR_W'(i));
         end
      end
   end

   always_comb begin
      wr_sel   = wr_en ? wr_dec : '0;
      pend_sel = pend_set ? pend_dec : '0;
`ifdef REG_FILE_ZERO_REG_EN
      wr_sel[0]   = 1'b0;
      pend_sel[0] = 1'b0;
`endif
      // set after clear: a newly issued producer outranks the completing one
      pend_d = (pend_q & ~wr_sel) | pend_sel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q  <= '0;
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) mem_q[i] <= wr_data;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      rf_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_port (
         .mem      (mem_q),
         .pend     (pend_q),
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
         .rd_data  (rd_data[i*DATA_W +: DATA_W]),
         .rd_ready (rd_ready[i])
      );
   end

   assign pend_vec = pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a bypassed and an unbypassed instance share stimulus;
// expected values are queued per cycle and checked by a negedge monitor.
module tb_reg_file_sb;

`ifdef REG_FILE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, wr_en, pend_set;
   logic [3:0]  wr_addr, pend_addr;
   logic [31:0] wr_data;
   logic [7:0]  rd_addr;
   logic [63:0] rd_data, nb_rd_data;
   logic [1:0]  rd_ready, nb_rd_ready;
   logic [15:0] pend_vec, nb_pend_vec;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
      .pend_set(pend_set), .pend_addr(pend_addr), .pend_vec(pend_vec)
   );

   reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_ready(nb_rd_ready),
      .pend_set(pend_set), .pend_addr(pend_addr), .pend_vec(nb_pend_vec)
   );

   typedef struct {
      int          cyc;
      int          step;
      bit          cd0;
      logic [31:0] d0;
      bit          cd1;
      logic [31:0] d1;
      bit          cr;
      logic [1:0]  r;
      bit          cp;
      logic [15:0] p;
      bit          cn;
      logic [31:0] nd0;
      logic [1:0]  nr;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   step_no = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int step, input string what, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL step%0d %s: got %h expected %h", step, what, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc != cyc) begin
            chk(e.step, "stale_entry_cycle", e.cyc, cyc);
         end else begin
            if (e.cd0) chk(e.step, "rd_data0", rd_data[31:0], e.d0);
            if (e.cd1) chk(e.step, "rd_data1", rd_data[63:32], e.d1);
            if (e.cr)  chk(e.step, "rd_ready", {30'd0, rd_ready}, {30'd0, e.r});
            if (e.cp)  chk(e.step, "pend_vec", {16'd0, pend_vec}, {16'd0, e.p});
            if (e.cn) begin
               chk(e.step, "nobypass_rd_data0", nb_rd_data[31:0], e.nd0);
               chk(e.step, "nobypass_rd_ready", {30'd0, nb_rd_ready}, {30'd0, e.nr});
            end
         end
      end
   end

   task automatic drive(input logic r, input logic we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] a0, input logic [3:0] a1,
                        input logic ps, input logic [3:0] pa);
      @(posedge clk);
      #1;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr = {a1, a0}; pend_set = ps; pend_addr = pa;
   endtask

   task automatic expect_now(input bit cd0, input logic [31:0] d0, input bit cd1,
                             input logic [31:0] d1, input bit cr, input logic [1:0] r,
                             input bit cp, input logic [15:0] p, input bit cn,
                             input logic [31:0] nd0, input logic [1:0] nr);
      exp_t e;
      step_no++;
      e.cyc = cyc; e.step = step_no;
      e.cd0 = cd0; e.d0 = d0; e.cd1 = cd1; e.d1 = d1;
      e.cr = cr; e.r = r; e.cp = cp; e.p = p;
      e.cn = cn; e.nd0 = nd0; e.nr = nr;
      sb.push_back(e);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; pend_set = 1'b0; pend_addr = '0;

      drive(1, 0, 0, 0, 0, 0, 0, 0);
      // reset state
      drive(0, 0, 0, 0, 5, 5, 0, 0);
      expect_now(1, 0, 1, 0, 1, 2'b11, 1, 16'h0000, 0, 0, 0);
      // write 3, read unrelated address in same cycle
      drive(0, 1, 3, 32'hDEADBEEF, 5, 5, 0, 0);
      expect_now(1, 0, 1, 0, 1, 2'b11, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 3, 2, 0, 0);
      expect_now(1, 32'hDEADBEEF, 1, 0, 0, 0, 1, 16'h0000, 1, 32'hDEADBEEF, 2'b11);
      // bypass on both ports vs stored value on the unbypassed instance
      drive(0, 1, 7, 32'h12345678, 7, 7, 0, 0);
      expect_now(1, 32'h12345678, 1, 32'h12345678, 1, 2'b11, 0, 0, 1, 0, 2'b11);
      drive(0, 0, 0, 0, 7, 3, 0, 0);
      expect_now(1, 32'h12345678, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h12345678, 2'b11);
      // scoreboard set on 9
      drive(0, 0, 0, 0, 9, 5, 1, 9);
      expect_now(0, 0, 0, 0, 1, 2'b11, 1, 16'h0000, 0, 0, 0);
      drive(0, 0, 0, 0, 9, 5, 0, 0);
      expect_now(0, 0, 0, 0, 1, 2'b10, 1, 16'h0200, 1, 0, 2'b10);
      // writeback to 9 forwards and clears
      drive(0, 1, 9, 32'h99, 9, 9, 0, 0);
      expect_now(1, 32'h99, 1, 32'h99, 1, 2'b11, 1, 16'h0200, 1, 0, 2'b00);
      drive(0, 0, 0, 0, 9, 7, 0, 0);
      expect_now(1, 32'h99, 1, 32'h12345678, 1, 2'b11, 1, 16'h0000, 0, 0, 0);
      // simultaneous set and clear on 4: set wins
      drive(0, 0, 0, 0, 4, 4, 1, 4);
      expect_now(0, 0, 0, 0, 1, 2'b11, 1, 16'h0000, 0, 0, 0);
      drive(0, 1, 4, 32'hA5, 4, 0, 1, 4);
      expect_now(1, 32'hA5, 0, 0, 1, 2'b11, 1, 16'h0010, 1, 0, 2'b10);
      drive(0, 0, 0, 0, 4, 9, 0, 0);
      expect_now(1, 32'hA5, 1, 32'h99, 1, 2'b10, 1, 16'h0010, 0, 0, 0);
      // set and clear on different addresses both apply
      drive(0, 1, 4, 32'h5A, 4, 11, 1, 11);
      expect_now(1, 32'h5A, 1, 0, 1, 2'b11, 1, 16'h0010, 0, 0, 0);
      drive(0, 0, 0, 0, 4, 11, 0, 0);
      expect_now(1, 32'h5A, 1, 0, 1, 2'b01, 1, 16'h0800, 0, 0, 0);
      // reset wins over a write in the same cycle
      drive(1, 1, 2, 32'hFF, 2, 3, 1, 6);
      expect_now(1, 32'hFF, 1, 32'hDEADBEEF, 1, 2'b11, 1, 16'h0800, 0, 0, 0);
      drive(0, 0, 0, 0, 2, 3, 0, 0);
      expect_now(1, 0, 1, 0, 1, 2'b11, 1, 16'h0000, 1, 0, 2'b11);
      // register 0: ordinary or hardwired zero depending on build
      drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
      expect_now(1, ZR ? 32'h0 : 32'hFFFFFFFF, 1, ZR ? 32'h0 : 32'hFFFFFFFF, 1, 2'b11,
                 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      expect_now(1, ZR ? 32'h0 : 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0,
                 1, ZR ? 32'h0 : 32'hFFFFFFFF, 2'b11);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      expect_now(0, 0, 0, 0, 1, 2'b11, 1, 16'h0000, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      expect_now(0, 0, 0, 0, 1, ZR ? 2'b11 : 2'b00, 1, ZR ? 16'h0000 : 16'h0001, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk(0, "scoreboard_leftover", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
